// File: rtl/fault_diag_pkg.sv
// fault_diag_pkg: shared definitions for the full-adder fault diagnosis block.
//   - state_e       : controller FSM states (IDLE / APPLY / DECODE)
//   - FAULT_NONE    : diagnosis code for a fault-free adder
//   - FAULT_UNKNOWN : diagnosis code when no signature matches
//   - SIG_TABLE     : golden {cout[7:0], sum[7:0]} responses, indexed by fault code
package fault_diag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    localparam logic [3:0] FAULT_NONE    = 4'h0;
    localparam logic [3:0] FAULT_UNKNOWN = 4'hF;

    localparam int NUM_SIGS = 9;

    // Entry k is the expected syndrome when fault k is present (0 = fault-free).
    // Bit j of each byte is the response to vector j = {a,b,c}.
    localparam logic [NUM_SIGS-1:0][15:0] SIG_TABLE = {
        16'h0096,   // 8
        16'h8096,   // 7
        16'hC096,   // 6
        16'hE800,   // 5
        16'hC0F0,   // 4
        16'hC03C,   // 3
        16'hA05A,   // 2
        16'h8866,   // 1
        16'hE896    // 0
    };

endpackage

// File: rtl/fault_diag_if.sv
// fault_diag_if: groups the run handshake, the adder-under-test stimulus and
// responses, and the diagnosis results.
//   master : drives start and the adder responses (sum/cout), observes the rest
//   slave  : the diagnosis engine (fault_diag)
interface fault_diag_if;
    logic        start;
    logic        a;
    logic        b;
    logic        c;
    logic        sum;
    logic        cout;
    logic        busy;
    logic        done;
    logic [15:0] syndrome;
    logic [3:0]  diag;
    logic        unknown;

    modport master (
        output start, sum, cout,
        input  a, b, c, busy, done, syndrome, diag, unknown
    );

    modport slave (
        input  start, sum, cout,
        output a, b, c, busy, done, syndrome, diag, unknown
    );
endinterface

// File: rtl/fault_diag_decode.sv
// fault_diag_decode: combinational syndrome lookup.
//   syndrome : captured {cout, sum} responses
//   diag     : matching fault code, FAULT_UNKNOWN when nothing matches
//   unknown  : high when the syndrome matches no table entry
// Table entries are distinct, so at most one entry can match.
module fault_diag_decode
    import fault_diag_pkg::*;
(
    input  logic [15:0] syndrome,
    output logic [3:0]  diag,
    output logic        unknown
);

    always_comb begin
        diag    = FAULT_UNKNOWN;
        unknown = 1'b1;
        for (int i = 0; i < NUM_SIGS; i++) begin
            if (syndrome == SIG_TABLE[i]) begin
                diag    = 4'(i);
                unknown = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fault_diag.sv
// fault_diag: applies all 8 input vectors to a full adder under test, captures
// its sum/cout responses into a 16-bit syndrome and decodes the fault location.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : fault_diag_if.slave (start, a/b/c, sum/cout, busy, done,
//              syndrome, diag, unknown)
//   fail_cnt : only with FAULT_DIAG_FAILCNT_EN -- saturating count of runs that
//              ended with a non-zero diagnosis; cleared only by rst
// Timing: start edge E0, vectors captured at E1..E8, result registered at E9,
// done high for the cycle after E9.
module fault_diag
    import fault_diag_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fault_diag_if.slave  bus
`ifdef FAULT_DIAG_FAILCNT_EN
    ,
    output logic [7:0]   fail_cnt
`endif
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] syndrome_q, syndrome_d;
    logic [3:0]  diag_q, diag_d;
    logic        unknown_q, unknown_d;
    logic        done_q, done_d;

    logic [3:0]  dec_diag;
    logic        dec_unknown;

    fault_diag_decode u_decode (
        .syndrome (syndrome_q),
        .diag     (dec_diag),
        .unknown  (dec_unknown)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            syndrome_q <= 16'h0000;
            diag_q     <= FAULT_NONE;
            unknown_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            syndrome_q <= syndrome_d;
            diag_q     <= diag_d;
            unknown_q  <= unknown_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        syndrome_d = syndrome_q;
        diag_d     = diag_q;
        unknown_d  = unknown_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_APPLY;
                    idx_d   = 3'd0;
                end
            end
            ST_APPLY: begin
                // sum goes to the low byte, cout to the high byte
                syndrome_d[{1'b0, idx_q}] = bus.sum;
                syndrome_d[{1'b1, idx_q}] = bus.cout;
                idx_d = idx_q + 3'd1;          // wraps 7 -> 0 on the last vector
                if (idx_q == 3'd7) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                diag_d    = dec_diag;
                unknown_d = dec_unknown;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

`ifdef FAULT_DIAG_FAILCNT_EN
    logic [7:0] fail_cnt_q, fail_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_q <= 8'h00;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Counts on the edge that registers the result, i.e. once per done pulse.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (state_q == ST_DECODE && dec_diag != FAULT_NONE && fail_cnt_q != 8'hFF) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
        end
    end

    assign fail_cnt = fail_cnt_q;
`endif

    // idx is held at 0 outside APPLY, so the stimulus is 0 in IDLE/DECODE.
    assign bus.a        = idx_q[2];
    assign bus.b        = idx_q[1];
    assign bus.c        = idx_q[0];
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.syndrome = syndrome_q;
    assign bus.diag     = diag_q;
    assign bus.unknown  = unknown_q;

endmodule

// File: tb/tb_fault_diag.sv
// tb_fault_diag: table-driven check of fault_diag against a fault-injectable
// full adder model, plus hand-written sequences for mid-run reset and
// back-to-back runs with start held high.
module tb_fault_diag;

    logic clk;
    logic rst;

    fault_diag_if bus ();

`ifdef FAULT_DIAG_FAILCNT_EN
    logic [7:0] fail_cnt;
`endif

    fault_diag dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef FAULT_DIAG_FAILCNT_EN
        ,
        .fail_cnt (fail_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test: fault k responds with the k-th table entry,
    // stuck_sum forces sum=1 on every vector.
    localparam logic [15:0] ADDER_RESP [9] = '{
        16'hE896, 16'h8866, 16'hA05A, 16'hC03C, 16'hC0F0,
        16'hE800, 16'hC096, 16'h8096, 16'h0096
    };
    int         err_sel;
    logic       stuck_sum;
    logic [2:0] vec;
    logic [15:0] resp;

    always_comb begin
        vec      = {bus.a, bus.b, bus.c};
        resp     = ADDER_RESP[err_sel];
        bus.sum  = stuck_sum ? 1'b1 : resp[{1'b0, vec}];
        bus.cout = resp[{1'b1, vec}];
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int          err;
        logic        stuck;
        logic [15:0] syn;
        logic [3:0]  diag;
        logic        unk;
    } vec_t;

    vec_t tv[10];

    // One complete run; checks latency, busy, one-cycle done and results.
    task automatic run_and_check(input string name, input logic [15:0] syn,
                                 input logic [3:0] dg, input logic unk);
        int n;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;                // E0
        bus.start = 1'b0;
        chk({name, " busy_after_start"}, 32'(bus.busy), 32'd1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n = i;
                break;
            end
            if (i == 8) chk({name, " busy_in_decode"}, 32'(bus.busy), 32'd1);
        end
        chk({name, " done_latency"}, 32'(n), 32'd9);
        chk({name, " syndrome"}, 32'(bus.syndrome), 32'(syn));
        chk({name, " diag"}, 32'(bus.diag), 32'(dg));
        chk({name, " unknown"}, 32'(bus.unknown), 32'(unk));
        chk({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk({name, " done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dcnt;
        int dpos [3];

        for (int k = 0; k < 9; k++) begin
            tv[k].err   = k;
            tv[k].stuck = 1'b0;
            tv[k].diag  = 4'(k);
            tv[k].unk   = 1'b0;
        end
        tv[0].syn = 16'hE896; tv[1].syn = 16'h8866; tv[2].syn = 16'hA05A;
        tv[3].syn = 16'hC03C; tv[4].syn = 16'hC0F0; tv[5].syn = 16'hE800;
        tv[6].syn = 16'hC096; tv[7].syn = 16'h8096; tv[8].syn = 16'h0096;
        tv[9] = '{err: 0, stuck: 1'b1, syn: 16'hE8FF, diag: 4'hF, unk: 1'b1};

        rst       = 1'b1;
        bus.start = 1'b0;
        err_sel   = 0;
        stuck_sum = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
        chk("reset syndrome", 32'(bus.syndrome), 32'd0);
        chk("reset diag", 32'(bus.diag), 32'd0);
        chk("reset unknown", 32'(bus.unknown), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            err_sel   = tv[i].err;
            stuck_sum = tv[i].stuck;
            run_and_check($sformatf("vec%0d", i), tv[i].syn, tv[i].diag, tv[i].unk);
        end
        stuck_sum = 1'b0;

        // Results hold between runs.
        repeat (3) @(posedge clk);
        #1;
        chk("hold syndrome", 32'(bus.syndrome), 32'hE8FF);
        chk("hold diag", 32'(bus.diag), 32'hF);

        // Reset asserted at E4 of a run.
        err_sel = 2;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;                // E0
        bus.start = 1'b0;
        repeat (4) @(posedge clk);         // E1..E4
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
        chk("midrst syndrome", 32'(bus.syndrome), 32'd0);
        chk("midrst diag", 32'(bus.diag), 32'd0);
        chk("midrst unknown", 32'(bus.unknown), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dcnt++;
        end
        chk("midrst no_done_no_busy", 32'(dcnt), 32'd0);
        run_and_check("after_rst", 16'hA05A, 4'd2, 1'b0);

        // Back-to-back runs with start held for 30 cycles, from a fresh reset.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        err_sel   = 3;
        bus.start = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 3; i++) dpos[i] = -1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk); #1;            // cyc 0 is E0 of the first run
            if (cyc == 29) bus.start = 1'b0;
            if (bus.done) begin
                if (dcnt < 3) dpos[dcnt] = cyc;
                dcnt++;
            end
        end
        chk("b2b done_count", 32'(dcnt), 32'd3);
        chk("b2b done0", 32'(dpos[0]), 32'd9);
        chk("b2b done1", 32'(dpos[1]), 32'd19);
        chk("b2b done2", 32'(dpos[2]), 32'd29);
        chk("b2b diag", 32'(bus.diag), 32'd3);
        chk("b2b syndrome", 32'(bus.syndrome), 32'hC03C);
`ifdef FAULT_DIAG_FAILCNT_EN
        chk("b2b fail_cnt", 32'(fail_cnt), 32'd3);
        // Fault-free run must not count.
        err_sel = 0;
        run_and_check("failcnt_clean", 16'hE896, 4'd0, 1'b0);
        chk("fail_cnt hold", 32'(fail_cnt), 32'd3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fault_diag.md
FAULT_DIAG -- requirements
Module: fault_diag

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request one diagnosis run; sampled only in IDLE.
REQ-004 a, b, c  output  1 each  test stimulus driven into the fault-injectable full adder under test.
REQ-005 sum, cout  input  1 each  adder-under-test responses; combinational from a/b/c within the same cycle.
REQ-006 busy  output  1  high while a run is in progress (APPLY or DECODE).
REQ-007 done  output  1  one-cycle pulse when the diagnosis result is updated.
REQ-008 syndrome  output  16  captured responses: [15:8] = cout per vector, [7:0] = sum per vector, bit k = vector k.
REQ-009 diag  output  4  diagnosed fault code, 0 = fault-free, 1..8 = fault location, 4'hF = unrecognised.
REQ-010 unknown  output  1  high when the syndrome matches no entry in the signature table.

Function
REQ-011 FSM states: IDLE, APPLY, DECODE; encoding in the shared package.
REQ-012 IDLE: a=b=c=0, busy=0; start=1 at edge E0 -> APPLY with idx=0.
REQ-013 APPLY: 3-bit idx drives a=idx[2], b=idx[1], c=idx[0] from registers.
REQ-014 Each APPLY edge captures sum into syndrome[idx] and cout into syndrome[8+idx], then increments idx.
REQ-015 Edges E1..E8 capture vectors 0..7; at E8 idx wraps 7->0 and the state moves to DECODE.
REQ-016 DECODE: compare syndrome with 9 golden signatures (codes 0..8); at E9 register diag/unknown, done=1 for one cycle, return to IDLE.
REQ-017 Fixed latency: done is high in the cycle after E9, 9 cycles after the start edge E0.
REQ-018 Exactly one signature matches -> diag = code, unknown=0; no match -> diag=4'hF, unknown=1.
REQ-019 Signatures (hex {cout,sum}): 0:E896 1:8866 2:A05A 3:C03C 4:C0F0 5:E800 6:C096 7:8096 8:0096; all distinct.
REQ-020 start while busy is ignored and is not queued; start held high re-launches a run on the first IDLE cycle after done.
REQ-021 syndrome, diag and unknown hold their values between runs; a new run overwrites syndrome progressively.
REQ-022 busy=1 from the cycle after E0 through the DECODE cycle, inclusive.

Reset
REQ-023 rst asserted at any time, including mid-APPLY, forces IDLE, idx=0, a=b=c=0, busy=0, done=0, syndrome=0, diag=0, unknown=0.
REQ-024 After reset release, the first start begins a complete run from vector 0; no partial run resumes.

Configuration
REQ-025 Macro FAULT_DIAG_FAILCNT_EN: when defined, adds an output fail_cnt[7:0] that increments on each done with diag!=0 and saturates at 8'hFF; it is cleared only by rst.
REQ-026 Without FAULT_DIAG_FAILCNT_EN, fail_cnt and its counter logic do not exist; all other behaviour is identical.

Structure
REQ-027 Package fault_diag_pkg holds the FSM state enum, the code constants (FAULT_NONE=0, FAULT_UNKNOWN=4'hF) and the 9-entry signature table.
REQ-028 Sub-module fault_diag_decode performs the combinational syndrome -> {diag, unknown} lookup; fault_diag instantiates it once.

Verification
REQ-029 Fault-free adder (err=0), start pulse -> done 9 cycles later, syndrome=16'hE896, diag=0, unknown=0.
REQ-030 Adder with err=5 -> syndrome=16'hE800, diag=5; adder with err=8 -> syndrome=16'h0096, diag=8.
REQ-031 Adder with err=1 -> syndrome=16'h8866, diag=1; sweep err=0..8 -> diag equals err each time.
REQ-032 Model forcing sum=1 on all vectors -> syndrome=16'hE8FF, diag=4'hF, unknown=1.
REQ-033 rst pulsed at E4 of a run -> all outputs 0, no done pulse; the next start gives a full correct run.
REQ-034 start held high for 30 cycles -> back-to-back runs with done every 10 cycles; with FAULT_DIAG_FAILCNT_EN and err=3, fail_cnt=3 after three runs.
